// File: rtl/updown_counter_pkg.sv
// Shared constants and the next-count function for the up/down counter.
// The function works on a fixed maximum width so that every counter instance can reuse it.
package updown_counter_pkg;

  localparam int MAX_W = 32;

  localparam logic MODE_DOWN = 1'b0;
  localparam logic MODE_UP   = 1'b1;
  localparam logic BEH_WRAP  = 1'b0;
  localparam logic BEH_SAT   = 1'b1;

  typedef struct packed {
    logic             evt;
    logic [MAX_W-1:0] value;
  } next_t;

  // The extra top bit holds the carry on the way up and the borrow on the way down.
  function automatic next_t next_count(input logic [MAX_W-1:0] count,
                                       input logic [MAX_W-1:0] step,
                                       input logic [MAX_W-1:0] limit,
                                       input logic             mode,
                                       input logic             sat);
    next_t        r;
    logic [MAX_W:0] s;
    logic [MAX_W:0] d;
    r.evt   = 1'b0;
    r.value = count;
    s = {1'b0, count} + {1'b0, step};
    d = {1'b0, count} - {1'b0, step};
    if (step != '0) begin
      if (mode == MODE_UP) begin
        if (s <= {1'b0, limit}) begin
          r.value = s[MAX_W-1:0];
        end else begin
          r.evt   = 1'b1;
          r.value = (sat == BEH_SAT) ? limit : '0;
        end
      end else if (d[MAX_W]) begin
        r.evt   = 1'b1;
        r.value = (sat == BEH_SAT) ? '0 : limit;
      end else if (d[MAX_W-1:0] > limit) begin
        r.evt   = 1'b1;
        r.value = limit;
      end else begin
        r.value = d[MAX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable limit, variable step,
// wrap/saturate behaviour, terminal-count pulse and sticky overflow flag.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int              STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ld,
  input  logic              clr,
  input  logic              mode,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf
);

  next_t            res;
  logic             unused_res;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  assign res        = next_count(MAX_W'(count), MAX_W'(step), MAX_W'(limit), mode, sat);
  assign unused_res = ^res;

  // Priority is load, then clear, then an enabled count; otherwise hold.
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (ld) begin
      count_nxt = d_in;
      ovf_nxt   = 1'b0;
    end else if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (en) begin
      count_nxt = res.value[WIDTH-1:0];
      tc_nxt    = res.evt;
      ovf_nxt   = ovf | res.evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: an independent behavioural model
// pushes expected results as stimulus is driven; they are popped after each edge.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, ld, clr, mode, sat;
  logic [3:0] step;
  logic [7:0] limit, d_in, count;
  logic       tc, ovf;

  logic        en_w, ld_w, clr_w, mode_w, sat_w;
  logic [3:0]  step_w;
  logic [15:0] limit_w, d_in_w, count_w;
  logic        tc_w, ovf_w;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   m_count = 0;
  int   m_ovf   = 0;

  always #5 clk = ~clk;

  updown_counter_mod dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .clr(clr), .mode(mode), .sat(sat),
    .step(step), .limit(limit), .d_in(d_in), .count(count), .tc(tc), .ovf(ovf)
  );

  updown_counter_mod #(.WIDTH(16), .STEP_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en_w), .ld(ld_w), .clr(clr_w), .mode(mode_w), .sat(sat_w),
    .step(step_w), .limit(limit_w), .d_in(d_in_w), .count(count_w), .tc(tc_w), .ovf(ovf_w)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Drives one cycle of stimulus, predicts the result, then compares it after the edge.
  task automatic applyStimulus(input string tag, input logic ld_v, input logic clr_v,
                               input logic en_v, input logic mode_v, input logic sat_v,
                               input int step_v, input int limit_v, input int d_v);
    int   tcv;
    int   s;
    exp_t e;
    exp_t o;
    ld = ld_v; clr = clr_v; en = en_v; mode = mode_v; sat = sat_v;
    step = step_v[3:0]; limit = limit_v[7:0]; d_in = d_v[7:0];
    tcv = 0;
    if (ld_v) begin
      m_count = d_v; m_ovf = 0;
    end else if (clr_v) begin
      m_count = 0; m_ovf = 0;
    end else if (en_v && step_v != 0) begin
      if (mode_v) begin
        s = m_count + step_v;
        if (s <= limit_v) m_count = s;
        else begin tcv = 1; m_count = sat_v ? limit_v : 0; end
      end else begin
        s = m_count - step_v;
        if (s < 0) begin tcv = 1; m_count = sat_v ? 0 : limit_v; end
        else if (s > limit_v) begin tcv = 1; m_count = limit_v; end
        else m_count = s;
      end
      if (tcv != 0) m_ovf = 1;
    end
    e.count = m_count[7:0];
    e.tc    = tcv[0];
    e.ovf   = m_ovf[0];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    checkOutput({tag, ".count"}, 32'(count), 32'(o.count));
    checkOutput({tag, ".tc"},    32'(tc),    32'(o.tc));
    checkOutput({tag, ".ovf"},   32'(ovf),   32'(o.ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    ld = 0; clr = 0; en = 0; mode = 0; sat = 0; step = 0; limit = 0; d_in = 0;
    ld_w = 0; clr_w = 0; en_w = 0; mode_w = 0; sat_w = 0; step_w = 0; limit_w = 0; d_in_w = 0;
    #8;
    checkOutput("rst.count", 32'(count), 32'h0);
    checkOutput("rst.tc",    32'(tc),    32'h0);
    checkOutput("rst.ovf",   32'(ovf),   32'h0);
    #4 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus("wrap_up", 0, 0, 1, 1, 0, 1, 9, 0);

    applyStimulus("sat_dn_ld", 1, 0, 0, 0, 1, 7, 200, 10);
    for (int i = 0; i < 4; i++) applyStimulus("sat_dn", 0, 0, 1, 0, 1, 7, 200, 0);

    applyStimulus("prio_all", 1, 1, 1, 1, 0, 1, 200, 8'h5A);
    applyStimulus("prio_clr", 0, 1, 1, 1, 0, 1, 200, 8'h33);

    applyStimulus("ovr_ld", 1, 0, 0, 0, 0, 1, 15, 200);
    applyStimulus("ovr_dn", 0, 0, 1, 0, 0, 1, 15, 0);
    applyStimulus("ovr_ld2", 1, 0, 0, 1, 0, 1, 15, 200);
    applyStimulus("ovr_up", 0, 0, 1, 1, 0, 1, 15, 0);

    for (int i = 0; i < 5; i++) applyStimulus("run5", 0, 0, 1, 1, 0, 5, 15, 0);
    for (int i = 0; i < 5; i++) applyStimulus("en_off", 0, 0, 0, 1, 0, 5, 15, 0);
    for (int i = 0; i < 2; i++) applyStimulus("step0", 0, 0, 1, 1, 0, 0, 15, 0);

    applyStimulus("lim0_ld", 1, 0, 0, 1, 1, 3, 0, 0);
    applyStimulus("lim0_up", 0, 0, 1, 1, 1, 3, 0, 0);
    applyStimulus("lim0_dn", 0, 0, 1, 0, 0, 3, 0, 0);

    applyStimulus("pin_ld", 1, 0, 0, 1, 1, 2, 20, 18);
    for (int i = 0; i < 3; i++) applyStimulus("pin_up", 0, 0, 1, 1, 1, 2, 20, 0);

    for (int i = 0; i < 60; i++) begin
      applyStimulus("rand", $urandom_range(7) == 0, $urandom_range(15) == 0,
                    $urandom_range(3) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    int'($urandom_range(15)), int'($urandom_range(255)), int'($urandom_range(255)));
    end

    applyStimulus("mid_ld", 1, 0, 0, 1, 0, 1, 200, 8'h37);
    ld = 0; en = 0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst.count", 32'(count), 32'h0);
    checkOutput("midrst.tc",    32'(tc),    32'h0);
    checkOutput("midrst.ovf",   32'(ovf),   32'h0);
    m_count = 0; m_ovf = 0;
    #3 rst_n = 1'b1;
    applyStimulus("post_rst", 0, 0, 1, 1, 0, 2, 200, 0);

    ld_w = 1; d_in_w = 16'hFFFE; limit_w = 16'hFFFF; step_w = 4'd3; mode_w = 1; sat_w = 0;
    @(posedge clk); #1;
    checkOutput("w16_ld.count", 32'(count_w), 32'hFFFE);
    ld_w = 0; en_w = 1;
    @(posedge clk); #1;
    checkOutput("w16_up.count", 32'(count_w), 32'h0);
    checkOutput("w16_up.tc",    32'(tc_w),    32'h1);
    checkOutput("w16_up.ovf",   32'(ovf_w),   32'h1);
    en_w = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
